// File: rtl/ddram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddram_pkg
// Description : Shared widths and record types for the ddram write path.
// Revision    : 1.0 - initial release
// ============================================================================
package ddram_pkg;

    localparam int DDR_AW  = 29;
    localparam int DDR_DW  = 64;
    localparam int DDR_BEW = 8;
    localparam int DDR_LW  = 8;

    typedef struct packed {
        logic [DDR_AW-1:0] addr;
        logic [DDR_LW-1:0] len;
    } desc_t;

    typedef struct packed {
        logic [DDR_DW-1:0]  data;
        logic [DDR_BEW-1:0] be;
    } word_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead head output and fill count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ddram_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : ddram_wr_packer
// Description : Write combiner grouping consecutive word writes into bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module ddram_wr_packer
    import ddram_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int MAX_BURST  = 64,
    parameter int DESC_DEPTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DDR_AW-1:0]  in_addr,
    input  logic [DDR_DW-1:0]  in_data,
    input  logic [DDR_BEW-1:0] in_be,
    input  logic               flush,
    output logic               idle,
    output logic [DDR_AW-1:0]  wr_addr,
    output logic [DDR_LW-1:0]  wr_burstcnt,
    output logic [DDR_DW-1:0]  wr_data,
    output logic [DDR_BEW-1:0] wr_be,
    output logic               wr_req,
    input  logic               wr_ack,
    input  logic               wr_busy
);
    localparam int LB  = $clog2(MAX_BURST);
    localparam int SW  = DDR_AW + 1;
    localparam int DCW = $clog2(DEPTH + 1);
    localparam int QCW = $clog2(DESC_DEPTH + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {O_IDLE = 1'b0, O_BURST = 1'b1} ostate_t;

    ostate_t            ostate_q;
    logic [DDR_AW-1:0]  run_base_q, run_base_d;
    logic [DDR_LW-1:0]  run_len_q, run_len_d;
    logic               run_open_q, run_open_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               flush_pend_q, flush_pend_d;
    logic               in_ready_q;
    logic [DDR_AW-1:0]  wr_addr_q;
    logic [DDR_LW-1:0]  wr_burstcnt_q;
    logic [DDR_LW-1:0]  remain_q;

    logic               accept, contig;
    logic               desc_push, desc_pop, data_pop;
    logic               data_empty, desc_empty;
    desc_t              desc_in, desc_head;
    word_t              word_in, word_head;
    logic [DCW-1:0]     data_count, data_count_nxt;
    logic [QCW-1:0]     desc_count, desc_count_nxt;

    assign word_in = '{data: in_data, be: in_be};

    sync_fifo #(.WIDTH($bits(word_t)), .DEPTH(DEPTH)) u_data_fifo (
        .clk(clk), .reset_n(reset_n), .push(accept), .wdata(word_in),
        .pop(data_pop), .rdata(word_head), .count(data_count), .empty(data_empty)
    );

    sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk(clk), .reset_n(reset_n), .push(desc_push), .wdata(desc_in),
        .pop(desc_pop), .rdata(desc_head), .count(desc_count), .empty(desc_empty)
    );

    // Run tracker: one descriptor push per edge; accept-driven closes win over timeout/flush.
    always_comb begin
        accept       = in_valid && in_ready_q;
        contig       = run_open_q && (in_addr[LB-1:0] != '0)
                       && (({1'b0, run_base_q} + SW'(run_len_q)) == {1'b0, in_addr});
        run_base_d   = run_base_q;
        run_len_d    = run_len_q;
        run_open_d   = run_open_q;
        timer_d      = timer_q;
        flush_pend_d = flush_pend_q || flush;
        desc_push    = 1'b0;
        desc_in      = '{addr: run_base_q, len: run_len_q};
        if (accept) begin
            timer_d = '0;
            if (contig) begin
                run_len_d = run_len_q + 8'd1;
                if (run_len_d == 8'(MAX_BURST)) begin
                    desc_push   = 1'b1;
                    desc_in.len = run_len_d;
                    run_open_d  = 1'b0;
                end
            end else begin
                desc_push  = run_open_q;
                run_base_d = in_addr;
                run_len_d  = 8'd1;
                run_open_d = 1'b1;
            end
        end else if (run_open_q && timer_q != TW'(TIMEOUT)) begin
            timer_d = timer_q + TW'(1);
        end
        if (!desc_push) begin
            if (!accept && run_open_q && timer_q >= TW'(TIMEOUT - 1)) begin
                if (desc_count < QCW'(DESC_DEPTH)) begin
                    desc_push  = 1'b1;
                    run_open_d = 1'b0;
                    timer_d    = '0;
                end
            end else if (flush_pend_d) begin
                if (!run_open_d) begin
                    flush_pend_d = 1'b0;
                end else if (desc_count < QCW'(DESC_DEPTH)) begin
                    desc_push    = 1'b1;
                    desc_in      = '{addr: run_base_d, len: run_len_d};
                    run_open_d   = 1'b0;
                    timer_d      = '0;
                    flush_pend_d = 1'b0;
                end
            end
        end
    end

    assign desc_pop       = (ostate_q == O_IDLE) && !desc_empty;
    assign data_pop       = (ostate_q == O_BURST) && wr_ack;
    assign data_count_nxt = data_count + DCW'(accept) - DCW'(data_pop);
    assign desc_count_nxt = desc_count + QCW'(desc_push) - QCW'(desc_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ostate_q      <= O_IDLE;
            run_base_q    <= '0;
            run_len_q     <= '0;
            run_open_q    <= 1'b0;
            timer_q       <= '0;
            flush_pend_q  <= 1'b0;
            in_ready_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_burstcnt_q <= '0;
            remain_q      <= '0;
        end else begin
            run_base_q   <= run_base_d;
            run_len_q    <= run_len_d;
            run_open_q   <= run_open_d;
            timer_q      <= timer_d;
            flush_pend_q <= flush_pend_d;
            in_ready_q   <= (data_count_nxt < DCW'(DEPTH)) && (desc_count_nxt < QCW'(DESC_DEPTH));
            case (ostate_q)
                O_IDLE: begin
                    if (!desc_empty) begin
                        wr_addr_q     <= desc_head.addr;
                        wr_burstcnt_q <= desc_head.len;
                        remain_q      <= desc_head.len;
                        ostate_q      <= O_BURST;
                    end
                end
                O_BURST: begin
                    if (wr_ack) begin
                        remain_q <= remain_q - 8'd1;
                        if (remain_q == 8'd1) ostate_q <= O_IDLE;
                    end
                end
                default: ostate_q <= O_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(wr_ack && (ostate_q == O_IDLE || !wr_busy)));
        end
    end

    // Request drops in the ack cycle so the controller never resamples the word just taken.
    assign wr_req      = (ostate_q == O_BURST) && !wr_ack;
    assign wr_data     = (ostate_q == O_BURST) ? word_head.data : '0;
    assign wr_be       = (ostate_q == O_BURST) ? word_head.be : '0;
    assign wr_addr     = wr_addr_q;
    assign wr_burstcnt = wr_burstcnt_q;
    assign in_ready    = in_ready_q;
    assign idle        = !run_open_q && !flush_pend_q && data_empty && desc_empty
                         && (ostate_q == O_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddram_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddram_wr_packer
// Description : Randomised bench with burst-grouping reference and ddram_ctrl model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddram_wr_packer;
    import ddram_pkg::*;

    localparam int DEPTH      = 256;
    localparam int MB         = 64;
    localparam int DESC_DEPTH = 8;
    localparam int TIMEOUT    = 16;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } wrec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        wr_ack = 1'b0;
    logic        wr_busy = 1'b0;
    logic [28:0] in_addr = '0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_be = '0;
    logic        in_ready, idle, wr_req;
    logic [28:0] wr_addr;
    logic [7:0]  wr_burstcnt, wr_be;
    logic [63:0] wr_data;

    wrec_t sent[$];
    wrec_t obs_words[$];
    desc_t exp_bursts[$];
    desc_t obs_bursts[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    ack_total = 0;
    int    burst_left = 0;
    int    burst_off = 0;
    logic  stall_acks = 1'b0;
    logic  req_seen = 1'b0;

    always #5 clk = ~clk;

    ddram_wr_packer #(
        .DEPTH(DEPTH), .MAX_BURST(MB), .DESC_DEPTH(DESC_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_be(in_be), .flush(flush), .idle(idle),
        .wr_addr(wr_addr), .wr_burstcnt(wr_burstcnt), .wr_data(wr_data),
        .wr_be(wr_be), .wr_req(wr_req), .wr_ack(wr_ack), .wr_busy(wr_busy)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ddram_ctrl model: samples wr_req at an edge, acks the following cycle after a random delay.
    initial begin : ctrl_model
        forever begin
            @(negedge clk);
            req_seen = wr_req && reset_n;
            if (wr_ack && reset_n) chk_eq("req_low_in_ack", 64'(wr_req), 64'd0);
            @(posedge clk);
            #1;
            if (!reset_n) begin
                wr_ack = 1'b0;
                wr_busy = 1'b0;
                burst_left = 0;
            end else if (wr_ack) begin
                wr_ack = 1'b0;
                if (burst_left == 0) wr_busy = 1'b0;
            end else if (req_seen && !stall_acks && $urandom_range(3) != 0) begin
                wr_ack = 1'b1;
                wr_busy = 1'b1;
                if (burst_left == 0) begin
                    burst_left = int'(wr_burstcnt);
                    burst_off = 0;
                    obs_bursts.push_back('{addr: wr_addr, len: wr_burstcnt});
                end
                obs_words.push_back('{addr: wr_addr + 29'(burst_off), data: wr_data, be: wr_be});
                burst_off++;
                burst_left--;
                ack_total++;
            end else if (req_seen) begin
                wr_busy = 1'b1;
            end
        end
    end

    task automatic send(input logic [28:0] a, input int gap);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_addr = a;
        in_data = {$urandom, $urandom};
        in_be = 8'($urandom);
        while (!in_ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk_eq("send_ready_timeout", 64'(n), 64'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sent.push_back('{addr: in_addr, data: in_data, be: in_be});
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic start_phase();
        sent.delete();
        obs_words.delete();
        obs_bursts.delete();
    endtask

    // Reference grouping: split the accepted address list wherever contiguity breaks,
    // a MAX_BURST-aligned address starts, or the burst is full.
    task automatic build_expected();
        logic [28:0] base, prev, a;
        int len;
        base = '0;
        prev = '0;
        len = 0;
        exp_bursts.delete();
        foreach (sent[i]) begin
            a = sent[i].addr;
            if (len == 0) begin
                base = a;
                len = 1;
            end else if (len == MB || ({1'b0, prev} + 30'd1) != {1'b0, a}
                         || (a & 29'(MB - 1)) == '0) begin
                exp_bursts.push_back('{addr: base, len: 8'(len)});
                base = a;
                len = 1;
            end else begin
                len++;
            end
            prev = a;
        end
        if (len != 0) exp_bursts.push_back('{addr: base, len: 8'(len)});
    endtask

    task automatic finish_phase(input string tag);
        int n;
        n = 0;
        while (!idle && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq({tag, "_idle"}, 64'(idle), 64'd1);
        build_expected();
        chk_eq({tag, "_nbursts"}, 64'(obs_bursts.size()), 64'(exp_bursts.size()));
        for (int i = 0; i < exp_bursts.size() && i < obs_bursts.size(); i++) begin
            chk_eq($sformatf("%s_base%0d", tag, i), 64'(obs_bursts[i].addr), 64'(exp_bursts[i].addr));
            chk_eq($sformatf("%s_len%0d", tag, i), 64'(obs_bursts[i].len), 64'(exp_bursts[i].len));
        end
        chk_eq({tag, "_nwords"}, 64'(obs_words.size()), 64'(sent.size()));
        for (int i = 0; i < sent.size() && i < obs_words.size(); i++) begin
            chk_eq($sformatf("%s_addr%0d", tag, i), 64'(obs_words[i].addr), 64'(sent[i].addr));
            chk_eq($sformatf("%s_data%0d", tag, i), obs_words[i].data, sent[i].data);
            chk_eq($sformatf("%s_be%0d", tag, i), 64'(obs_words[i].be), 64'(sent[i].be));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [28:0] base;
        int cnt, len, n, a0;

        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_wr_req", 64'(wr_req), 64'd0);
        chk_eq("rst_idle", 64'(idle), 64'd1);
        chk_eq("rst_in_ready", 64'(in_ready), 64'd0);
        chk_eq("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk_eq("rst_burstcnt", 64'(wr_burstcnt), 64'd0);
        chk_eq("rst_wr_data", wr_data, 64'd0);
        chk_eq("rst_wr_be", 64'(wr_be), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("rst_in_ready_rise", 64'(in_ready), 64'd1);

        start_phase();
        for (int i = 0; i < 4; i++) send(29'h100 + 29'(i), 0);
        do_flush();
        finish_phase("seq4");

        start_phase();
        send(29'h200, 1);
        send(29'h201, 1);
        send(29'h300, 1);
        do_flush();
        finish_phase("break");

        start_phase();
        for (int i = 0; i < 65; i++) send(29'h1000 + 29'(i), 0);
        finish_phase("timeout");

        start_phase();
        for (int i = 0; i < 4; i++) send(29'h3E + 29'(i), 0);
        do_flush();
        finish_phase("align");

        start_phase();
        send(29'h1FFFFFFF, 0);
        send(29'h0, 0);
        do_flush();
        finish_phase("wrap");

        for (int s = 0; s < 4; s++) begin
            start_phase();
            cnt = 0;
            while (cnt < 30) begin
                base = 29'($urandom);
                if ($urandom_range(1) == 0) base = {base[28:6], 6'h3C};
                len = int'($urandom_range(1, 10));
                for (int j = 0; j < len; j++) begin
                    send(base + 29'(j), int'($urandom_range(2, 5)));
                    cnt++;
                end
            end
            if (s % 2 == 0) do_flush();
            finish_phase("rnd");
        end

        start_phase();
        stall_acks = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) send(29'h4000 + 29'(i), 0);
            end
            begin
                repeat (500) @(posedge clk);
                #1;
                chk_eq("stall_accepted", 64'(sent.size()), 64'd256);
                chk_eq("stall_in_ready", 64'(in_ready), 64'd0);
                chk_eq("stall_no_acks", 64'(obs_words.size()), 64'd0);
                stall_acks = 1'b0;
            end
        join
        do_flush();
        finish_phase("stall");

        start_phase();
        a0 = ack_total;
        for (int i = 0; i < 64; i++) send(29'h8000 + 29'(i), 0);
        n = 0;
        while ((ack_total - a0) < 10 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq("mid_burst_acks", 64'(ack_total - a0), 64'd10);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_eq("async_rst_wr_req", 64'(wr_req), 64'd0);
        chk_eq("async_rst_idle", 64'(idle), 64'd1);
        chk_eq("async_rst_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start_phase();
        send(29'h9000, 0);
        do_flush();
        finish_phase("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
